// File: rtl/im_fetch_if.sv
// Fetch/response/load bundle between the CPU fetch stage (master) and the
// instruction-memory responder (slave).
interface im_fetch_if #(
  parameter int IW = 12
) ();
  logic          req_valid;
  logic          req_ready;
  logic [31:0]   req_addr;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [31:0]   rsp_instr;
  logic [31:0]   rsp_addr;
  logic          rsp_err;
  logic          ld_en;
  logic [IW-1:0] ld_index;
  logic [31:0]   ld_data;

  modport master (
    output req_valid, req_addr, rsp_ready, ld_en, ld_index, ld_data,
    input  req_ready, rsp_valid, rsp_instr, rsp_addr, rsp_err
  );

  modport slave (
    input  req_valid, req_addr, rsp_ready, ld_en, ld_index, ld_data,
    output req_ready, rsp_valid, rsp_instr, rsp_addr, rsp_err
  );
endinterface

// File: rtl/im_fetch_port.sv
// Instruction-memory responder: word array read on request accept, answered
// through a 2-entry response FIFO. Optional IM_ADDR_CHECK_EN flags bad addresses.
module im_fetch_port #(
  parameter int          DEPTH_WORDS = 4096,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_3000,
  localparam int         IW          = $clog2(DEPTH_WORDS)
) (
  input logic       clk,
  input logic       reset,
  im_fetch_if.slave bus
);

  logic [31:0]   mem [DEPTH_WORDS];

  logic [31:0]   fifo_instr [2];
  logic [31:0]   fifo_addr  [2];
  logic          fifo_err   [2];
  logic          wr_ptr;
  logic          rd_ptr;
  logic [1:0]    cnt;

  logic          push;
  logic          pop;
  logic [31:0]   offset;
  logic [IW-1:0] idx;
  logic          fault;
  logic [31:0]   rd_word;

  always_comb begin
    offset = bus.req_addr - BASE_ADDR;
    idx    = IW'(offset >> 2);
`ifdef IM_ADDR_CHECK_EN
    fault  = (bus.req_addr[1:0] != 2'b00) ||
             (bus.req_addr < BASE_ADDR) ||
             ((offset >> 2) >= 32'(DEPTH_WORDS));
`else
    fault  = 1'b0;
`endif
    // Faulting requests never touch the array; the slot carries a zero word.
    rd_word = fault ? 32'd0 : mem[idx];
  end

  // Ready is held low during reset and whenever a load owns the array port.
  always_comb begin
    bus.req_ready = reset && (cnt != 2'd2) && !bus.ld_en;
    bus.rsp_valid = (cnt != 2'd0);
    bus.rsp_instr = bus.rsp_valid ? fifo_instr[rd_ptr] : 32'd0;
    bus.rsp_addr  = bus.rsp_valid ? fifo_addr[rd_ptr]  : 32'd0;
    bus.rsp_err   = bus.rsp_valid ? fifo_err[rd_ptr]   : 1'b0;
  end

  always_comb begin
    push = bus.req_valid && bus.req_ready;
    pop  = bus.rsp_valid && bus.rsp_ready;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt    <= 2'd0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      for (int i = 0; i < 2; i++) begin
        fifo_instr[i] <= 32'd0;
        fifo_addr[i]  <= 32'd0;
        fifo_err[i]   <= 1'b0;
      end
    end else begin
      if (push) begin
        fifo_instr[wr_ptr] <= rd_word;
        fifo_addr[wr_ptr]  <= bus.req_addr;
        fifo_err[wr_ptr]   <= fault;
        wr_ptr             <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      case ({push, pop})
        2'b10:   cnt <= cnt + 2'd1;
        2'b01:   cnt <= cnt - 2'd1;
        default: cnt <= cnt;
      endcase
    end
  end

  // Program store survives reset; only the load port writes it.
  always_ff @(posedge clk) begin
    if (bus.ld_en) begin
      mem[bus.ld_index] <= bus.ld_data;
    end
  end

endmodule
